// File: rtl/seven_segment_scanner.sv
// rtl/seven_segment_scanner.sv - time-multiplexed common-anode seven-segment display scanner
module seven_segment_scanner #(
   parameter int NUM_DIGITS   = 8,
   parameter int COUNT_PERIOD = 100000,
   parameter int GUARD_CYCLES = 2,
   parameter int LZ_SUPPRESS  = 0
) (
   input  logic                    clk_in,
   input  logic                    rst_in,
   input  logic [4*NUM_DIGITS-1:0] val_in,
   input  logic [NUM_DIGITS-1:0]   dp_in,
   input  logic [NUM_DIGITS-1:0]   blank_in,
   output logic [6:0]              cat_out,
   output logic                    dp_out,
   output logic [NUM_DIGITS-1:0]   an_out,
   output logic                    frame_out
);

   localparam int CW = $clog2(COUNT_PERIOD);
   localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
   localparam logic [CW-1:0] COUNT_LAST = CW'(COUNT_PERIOD - 1);
   localparam logic [IW-1:0] INDEX_LAST = IW'(NUM_DIGITS - 1);

   if (NUM_DIGITS < 1 || NUM_DIGITS > 16) begin : g_bad_num_digits
      $error("seven_segment_scanner: NUM_DIGITS must be in 1..16");
   end
   if (COUNT_PERIOD < 2) begin : g_bad_count_period
      $error("seven_segment_scanner: COUNT_PERIOD must be at least 2");
   end
   if (GUARD_CYCLES < 0 || GUARD_CYCLES >= COUNT_PERIOD) begin : g_bad_guard
      $error("seven_segment_scanner: GUARD_CYCLES must be in 0..COUNT_PERIOD-1");
   end

   logic [CW-1:0]           count;
   logic [IW-1:0]           index;
   logic [4*NUM_DIGITS-1:0] snap_val;
   logic [NUM_DIGITS-1:0]   snap_dp;
   logic [NUM_DIGITS-1:0]   snap_blank;

   logic                    wrap;
   logic                    last_digit;
   logic                    capture;
   logic                    guard;
   logic                    tail_zero;
   logic [3:0]              cur_nib;
   logic                    cur_dp;
   logic                    cur_dark;
   logic [NUM_DIGITS-1:0]   an_sel;

   // Segment pattern a..g (bit0 = a), active-high; inverted at the pins.
   function automatic logic [6:0] seg_decode(input logic [3:0] nib);
      logic [6:0] seg;
      case (nib)
         4'h0: seg = 7'h3F;
         4'h1: seg = 7'h06;
         4'h2: seg = 7'h5B;
         4'h3: seg = 7'h4F;
         4'h4: seg = 7'h66;
         4'h5: seg = 7'h6D;
         4'h6: seg = 7'h7D;
         4'h7: seg = 7'h07;
         4'h8: seg = 7'h7F;
         4'h9: seg = 7'h6F;
         4'hA: seg = 7'h77;
         4'hB: seg = 7'h7C;
         4'hC: seg = 7'h39;
         4'hD: seg = 7'h5E;
         4'hE: seg = 7'h79;
         default: seg = 7'h71;
      endcase
      return seg;
   endfunction

   // Slot timing: end-of-slot, end-of-frame capture point and guard window.
   always_comb begin
      wrap       = (count == COUNT_LAST);
      last_digit = (index == INDEX_LAST);
      capture    = wrap && last_digit;
      guard      = (int'(count) < GUARD_CYCLES);
   end

   // Select the active digit from the snapshot; leading zeros are tracked from the top digit down.
   always_comb begin
      tail_zero = 1'b1;
      cur_nib   = 4'h0;
      cur_dp    = 1'b0;
      cur_dark  = 1'b0;
      an_sel    = '1;
      for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
         tail_zero = tail_zero && (snap_val[4*k +: 4] == 4'h0);
         if (k == int'(index)) begin
            cur_nib   = snap_val[4*k +: 4];
            cur_dp    = snap_dp[k];
            cur_dark  = snap_blank[k] || ((LZ_SUPPRESS != 0) && (k > 0) && tail_zero);
            an_sel[k] = 1'b0;
         end
      end
   end

   // Slot counter and digit index; the index steps when the slot counter wraps.
   always_ff @(posedge clk_in) begin
      if (!rst_in) begin
         count <= '0;
         index <= '0;
      end else begin
         count <= wrap ? '0 : count + CW'(1);
         if (wrap) begin
            index <= last_digit ? '0 : index + IW'(1);
         end
      end
   end

   // Frame snapshot: inputs are sampled only at the last cycle of the last slot so a frame never tears.
   always_ff @(posedge clk_in) begin
      if (!rst_in) begin
         snap_val   <= '0;
         snap_dp    <= '0;
         snap_blank <= '0;
         frame_out  <= 1'b0;
      end else begin
         frame_out <= capture;
         if (capture) begin
            snap_val   <= val_in;
            snap_dp    <= dp_in;
            snap_blank <= blank_in;
         end
      end
   end

   // Registered pin drivers: all dark during the guard window, otherwise one anode and its digit.
   always_ff @(posedge clk_in) begin
      if (!rst_in) begin
         an_out  <= '1;
         cat_out <= 7'h7F;
         dp_out  <= 1'b1;
      end else if (guard) begin
         an_out  <= '1;
         cat_out <= 7'h7F;
         dp_out  <= 1'b1;
      end else begin
         an_out  <= an_sel;
         cat_out <= cur_dark ? 7'h7F : ~seg_decode(cur_nib);
         dp_out  <= cur_dark ? 1'b1 : ~cur_dp;
      end
   end

endmodule

// File: tb/tb_seven_segment_scanner.sv
// tb/tb_seven_segment_scanner.sv - self-checking bench for seven_segment_scanner
module tb_seven_segment_scanner;

   localparam int N  = 4;
   localparam int CP = 8;
   localparam int G  = 2;
   localparam int FRAME = N * CP;

   logic        clk = 1'b0;
   logic        rst;
   logic [15:0] val;
   logic [3:0]  dp;
   logic [3:0]  blank;
   logic [6:0]  cat;
   logic        dpo;
   logic [3:0]  an;
   logic        fr;
   logic [6:0]  cat_lz;
   logic        dpo_lz;
   logic [3:0]  an_lz;
   logic        fr_lz;

   always #5 clk = ~clk;

   seven_segment_scanner #(
      .NUM_DIGITS(N), .COUNT_PERIOD(CP), .GUARD_CYCLES(G), .LZ_SUPPRESS(0)
   ) dut (
      .clk_in(clk), .rst_in(rst), .val_in(val), .dp_in(dp), .blank_in(blank),
      .cat_out(cat), .dp_out(dpo), .an_out(an), .frame_out(fr)
   );

   seven_segment_scanner #(
      .NUM_DIGITS(N), .COUNT_PERIOD(CP), .GUARD_CYCLES(G), .LZ_SUPPRESS(1)
   ) dut_lz (
      .clk_in(clk), .rst_in(rst), .val_in(val), .dp_in(dp), .blank_in(blank),
      .cat_out(cat_lz), .dp_out(dpo_lz), .an_out(an_lz), .frame_out(fr_lz)
   );

   typedef struct {
      logic [15:0] val;
      logic [3:0]  dp;
      logic [3:0]  blank;
      int          drive_at;
      logic [27:0] cat;
      logic [27:0] cat_lz;
      logic [3:0]  dpo;
   } vec_t;

   typedef struct {
      int         digit;
      logic [6:0] cat;
      logic [6:0] cat_lz;
      logic       dp;
   } exp_t;

   vec_t vecs[11];
   exp_t sb[$];
   int   errors = 0;
   int   checks = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %0h required %0h at %0t", name, act, req, $time);
      end
   endtask

   task automatic drive(input int i);
      val   = vecs[i].val;
      dp    = vecs[i].dp;
      blank = vecs[i].blank;
   endtask

   task automatic chk_reset_values(input string tag);
      chk({tag, "_an"}, an, 4'hF);
      chk({tag, "_cat"}, cat, 7'h7F);
      chk({tag, "_dp"}, dpo, 1'b1);
      chk({tag, "_frame"}, fr, 1'b0);
      chk({tag, "_an_lz"}, an_lz, 4'hF);
      chk({tag, "_cat_lz"}, cat_lz, 7'h7F);
   endtask

   // One full frame of samples displaying vecs[vi]; vecs[nxt] is driven at its drive_at sample.
   task automatic run_window(input int vi, input int nxt);
      int         low_cnt[N];
      int         guard_cnt;
      logic [3:0] prev_an;
      logic [3:0] exp_an;
      bit         have;
      exp_t       cur;
      exp_t       e;
      guard_cnt = 0;
      prev_an   = 4'hF;
      have      = 1'b0;
      cur       = '{0, 7'h7F, 7'h7F, 1'b1};
      for (int k = 0; k < N; k++) begin
         low_cnt[k] = 0;
         e.digit  = k;
         e.cat    = vecs[vi].cat[7*k +: 7];
         e.cat_lz = vecs[vi].cat_lz[7*k +: 7];
         e.dp     = vecs[vi].dpo[k];
         sb.push_back(e);
      end
      for (int s = 0; s < FRAME; s++) begin
         if (nxt >= 0 && s == vecs[nxt].drive_at) drive(nxt);
         @(posedge clk);
         @(negedge clk);
         chk("frame", fr, (s == FRAME - 1));
         chk("frame_lz", fr_lz, (s == FRAME - 1));
         if (an == 4'hF) begin
            guard_cnt++;
            chk("guard_cat", cat, 7'h7F);
            chk("guard_dp", dpo, 1'b1);
            chk("guard_an_lz", an_lz, 4'hF);
            chk("guard_cat_lz", cat_lz, 7'h7F);
         end else begin
            if (prev_an == 4'hF) begin
               if (sb.size() == 0) begin
                  checks++;
                  errors++;
                  have = 1'b0;
                  $display("FAIL scoreboard_underflow: got extra slot an=%0h required none", an);
               end else begin
                  cur  = sb.pop_front();
                  have = 1'b1;
               end
            end
            if (have) begin
               exp_an = ~(4'b0001 << cur.digit);
               chk("anode", an, exp_an);
               chk("anode_lz", an_lz, exp_an);
               chk("cat", cat, cur.cat);
               chk("dp", dpo, cur.dp);
               chk("cat_lz", cat_lz, cur.cat_lz);
               chk("dp_lz", dpo_lz, cur.dp);
            end
            for (int k = 0; k < N; k++) if (!an[k]) low_cnt[k]++;
         end
         prev_an = an;
      end
      chk("guard_cycles", guard_cnt, 2 * N);
      for (int k = 0; k < N; k++) chk("anode_low_cycles", low_cnt[k], CP - G);
      chk("scoreboard_drained", sb.size(), 0);
      sb.delete();
   endtask

   initial begin
      vecs[0]  = '{16'h0000, 4'h0, 4'h0, 0, {7'h40, 7'h40, 7'h40, 7'h40}, {7'h7F, 7'h7F, 7'h7F, 7'h40}, 4'hF};
      vecs[1]  = '{16'hFEDC, 4'h0, 4'h0, 0, {7'h0E, 7'h06, 7'h21, 7'h46}, {7'h0E, 7'h06, 7'h21, 7'h46}, 4'hF};
      vecs[2]  = '{16'hBA98, 4'h0, 4'h0, 0, {7'h03, 7'h08, 7'h10, 7'h00}, {7'h03, 7'h08, 7'h10, 7'h00}, 4'hF};
      vecs[3]  = '{16'h7654, 4'h0, 4'h0, 0, {7'h78, 7'h02, 7'h12, 7'h19}, {7'h78, 7'h02, 7'h12, 7'h19}, 4'hF};
      vecs[4]  = '{16'h3210, 4'h0, 4'h0, 0, {7'h30, 7'h24, 7'h79, 7'h40}, {7'h30, 7'h24, 7'h79, 7'h40}, 4'hF};
      vecs[5]  = '{16'h1234, 4'h0, 4'h0, 0, {7'h79, 7'h24, 7'h30, 7'h19}, {7'h79, 7'h24, 7'h30, 7'h19}, 4'hF};
      vecs[6]  = '{16'h5678, 4'h0, 4'h0, 13, {7'h12, 7'h02, 7'h78, 7'h00}, {7'h12, 7'h02, 7'h78, 7'h00}, 4'hF};
      vecs[7]  = '{16'h8888, 4'b0101, 4'b0100, 0, {7'h00, 7'h7F, 7'h00, 7'h00}, {7'h00, 7'h7F, 7'h00, 7'h00}, 4'b1110};
      vecs[8]  = '{16'h0070, 4'h0, 4'h0, 0, {7'h40, 7'h40, 7'h78, 7'h40}, {7'h7F, 7'h7F, 7'h78, 7'h40}, 4'hF};
      vecs[9]  = '{16'h0000, 4'h0, 4'h0, 0, {7'h40, 7'h40, 7'h40, 7'h40}, {7'h7F, 7'h7F, 7'h7F, 7'h40}, 4'hF};
      vecs[10] = '{16'h0100, 4'h0, 4'h0, 0, {7'h40, 7'h79, 7'h40, 7'h40}, {7'h7F, 7'h79, 7'h40, 7'h40}, 4'hF};

      rst = 1'b0;
      drive(1);
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         chk_reset_values("reset");
      end
      rst = 1'b1;

      for (int i = 0; i < 10; i++) run_window(i, i + 1);
      run_window(10, -1);

      repeat (20) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      chk_reset_values("midscan_reset");
      rst = 1'b1;
      run_window(0, -1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
